// File: rtl/mux_arb_pkg.sv
// Shared definitions for 2:1 mux arbitration.
//   state_e : arbiter ownership state (no owner, A owns, B owns)
//   SEL_A   : mux select value that passes input A (S = 1)
//   SEL_B   : mux select value that passes input B (S = 0)
package mux_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_e;

   localparam logic SEL_A = 1'b1;
   localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/mux2_dw.sv
// DW-wide 2:1 mux modelling the transmission-gate mux on the shared line.
//   sel : 1 passes in1, 0 passes in0
//   in1 : data input selected when sel = 1
//   in0 : data input selected when sel = 0
//   y   : mux output
module mux2_dw #(
   parameter int DW = 8
) (
   input  logic          sel,
   input  logic [DW-1:0] in1,
   input  logic [DW-1:0] in0,
   output logic [DW-1:0] y
);

   assign y = sel ? in1 : in0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux output between requesters A and B.
// Each grant is capped at MAX_HOLD cycles while the other side is waiting.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   req_a    : A requests the line (level, held until done)
//   data_a   : A data, sampled while A is granted
//   req_b    : B requests the line
//   data_b   : B data, sampled while B is granted
//   sel      : mux select, 1 = A passes, 0 = B passes
//   gnt_a    : A owns the line
//   gnt_b    : B owns the line
//   data_out : registered mux output, one cycle behind the grant
//   valid    : data_out carries granted data this cycle
module mux2_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int DW       = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_a,
   input  logic [DW-1:0] data_a,
   input  logic          req_b,
   input  logic [DW-1:0] data_b,
   output logic          sel,
   output logic          gnt_a,
   output logic          gnt_b,
   output logic [DW-1:0] data_out,
   output logic          valid
);

   localparam int             CW        = $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0]  HOLD_LAST = CW'(MAX_HOLD - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   hold_q, hold_d;
   logic            last_a_q, last_a_d;   // 1 = A was the most recent owner
   logic            sel_q, sel_d;
   logic [DW-1:0]   data_q;
   logic            valid_q;
   logic [DW-1:0]   mux_y;

   mux2_dw #(.DW(DW)) u_mux (
      .sel (sel_q),
      .in1 (data_a),
      .in0 (data_b),
      .y   (mux_y)
   );

   always_comb begin
      state_d  = state_q;
      hold_d   = '0;
      last_a_d = last_a_q;
      case (state_q)
         IDLE: begin
            if (req_a && req_b) state_d = last_a_q ? OWN_B : OWN_A;
            else if (req_a)     state_d = OWN_A;
            else if (req_b)     state_d = OWN_B;
         end
         OWN_A: begin
            if (!req_a) begin
               state_d = req_b ? OWN_B : IDLE;
            end else if (req_b) begin
               // The count only runs while B is waiting; reaching the cap forces handover.
               if (hold_q == HOLD_LAST) state_d = OWN_B;
               else                     hold_d  = hold_q + CW'(1);
            end
         end
         OWN_B: begin
            if (!req_b) begin
               state_d = req_a ? OWN_A : IDLE;
            end else if (req_a) begin
               if (hold_q == HOLD_LAST) state_d = OWN_A;
               else                     hold_d  = hold_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) hold_d = '0;
      if (state_d == OWN_A) last_a_d = 1'b1;
      if (state_d == OWN_B) last_a_d = 1'b0;
      // Select is derived from the next state so it is a clean register output.
      sel_d = (state_d == OWN_A) ? SEL_A : SEL_B;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         hold_q   <= '0;
         last_a_q <= 1'b0;
         sel_q    <= SEL_B;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         last_a_q <= last_a_d;
         sel_q    <= sel_d;
         // Hold the previous word while nobody owns the line.
         if (gnt_a || gnt_b) data_q <= mux_y;
         valid_q  <= gnt_a | gnt_b;
      end
   end

   assign gnt_a    = (state_q == OWN_A);
   assign gnt_b    = (state_q == OWN_B);
   assign sel      = sel_q;
   assign data_out = data_q;
   assign valid    = valid_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
module tb_mux2_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic       req_a, req_b;
   logic [7:0] data_a, data_b;
   logic       sel, gnt_a, gnt_b, valid;
   logic [7:0] data_out;

   int n_tests = 0;
   int n_fail  = 0;

   mux2_rr_arbiter #(.DW(8), .MAX_HOLD(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_a    (req_a),
      .data_a   (data_a),
      .req_b    (req_b),
      .data_b   (data_b),
      .sel      (sel),
      .gnt_a    (gnt_a),
      .gnt_b    (gnt_b),
      .data_out (data_out),
      .valid    (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic exp_a;
      rst_n  = 1'b0;
      req_a  = 1'b1;
      req_b  = 1'b1;
      data_a = 8'hA1;
      data_b = 8'h5A;

      // Reset held with both requesting
      step();
      step();
      check("rst_gnt_a", gnt_a, 0);
      check("rst_gnt_b", gnt_b, 0);
      check("rst_sel", sel, 0);
      check("rst_valid", valid, 0);
      check("rst_data", data_out, 0);
      rst_n = 1'b1;

      // Contention: AAAABBBBAAAA
      for (int i = 0; i < 12; i++) begin
         step();
         exp_a = ((i / 4) % 2) == 0;
         check($sformatf("cont_gnt_a[%0d]", i), gnt_a, exp_a);
         check($sformatf("cont_gnt_b[%0d]", i), gnt_b, !exp_a);
         check($sformatf("cont_sel[%0d]", i), sel, exp_a);
         check($sformatf("cont_excl[%0d]", i), gnt_a & gnt_b, 0);
         if (i == 0) begin
            check("cont_valid0", valid, 0);
         end else begin
            check($sformatf("cont_valid[%0d]", i), valid, 1);
            check($sformatf("cont_data[%0d]", i), data_out,
                  (((i - 1) / 4) % 2) == 0 ? 8'hA1 : 8'h5A);
         end
      end

      // Early release at the last A cycle: B next, counter restarted
      req_a = 1'b0;
      step();
      check("early_gnt_b", gnt_b, 1);
      check("early_data_a", data_out, 8'hA1);
      req_a = 1'b1;
      step();
      check("early_data_b", data_out, 8'h5A);
      check("early_hold2", gnt_b, 1);
      step();
      check("early_hold3", gnt_b, 1);
      step();
      check("early_hold4", gnt_b, 1);
      step();
      check("early_back_a", gnt_a, 1);

      // Round robin from IDLE after A was served
      req_a  = 1'b0;
      req_b  = 1'b0;
      step();
      check("idle_gnt_a", gnt_a, 0);
      check("idle_gnt_b", gnt_b, 0);
      check("idle_sel", sel, 0);
      check("idle_valid1", valid, 1);
      step();
      check("idle_valid0", valid, 0);
      check("idle_hold_data", data_out, 8'hA1);
      data_b = 8'hC3;
      req_a  = 1'b1;
      req_b  = 1'b1;
      step();
      check("rr_gnt_b", gnt_b, 1);
      check("rr_gnt_a", gnt_a, 0);

      // Solo B
      req_a = 1'b0;
      req_b = 1'b0;
      step();
      step();
      check("solo_pre_idle", gnt_b, 0);
      data_b = 8'h5A;
      req_b  = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         step();
         check($sformatf("solo_gnt_b[%0d]", i), gnt_b, 1);
         check($sformatf("solo_sel[%0d]", i), sel, 0);
         if (i >= 2) begin
            check($sformatf("solo_valid[%0d]", i), valid, 1);
            check($sformatf("solo_data[%0d]", i), data_out, 8'h5A);
         end
      end

      // Async reset mid-grant
      req_a = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_gnt_b", gnt_b, 0);
      check("arst_gnt_a", gnt_a, 0);
      check("arst_sel", sel, 0);
      check("arst_valid", valid, 0);
      check("arst_data", data_out, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      check("arst_first_a", gnt_a, 1);
      check("arst_first_b", gnt_b, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
